// File: rtl/uart_msg_framer_if.sv
// Purpose : bundles the UART-RX-facing and reader-facing signals of uart_msg_framer.
// Latency : n/a (wiring only).
// Backpressure: none on the RX side (rx_ready is tied high); the reader pops with RD_REQ / LEN_POP.
// Ports   : rx_data/rx_valid/rx_busy/rx_ready  - byte stream from the UART RX core
//           FIFO_Q/RD_REQ                      - show-ahead word FIFO read port
//           MSG_VALID/MSG_LEN/MSG_PAD/LEN_POP  - per-message descriptor read port
//           OVERFLOW/DROP_CNT                  - drop reporting
//           MSG_CSUM/CSUM_OK                   - only when MSG_CHECKSUM_EN is defined
// Modports: master = RX core plus reader side; slave = the framer.
interface uart_msg_framer_if #(
    parameter int WORD_BYTES  = 2,
    parameter int WDEPTH_LOG2 = 7
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_busy;
    logic                    rx_ready;
    logic [8*WORD_BYTES-1:0] FIFO_Q;
    logic                    RD_REQ;
    logic                    MSG_VALID;
    logic [WDEPTH_LOG2:0]    MSG_LEN;
    logic [1:0]              MSG_PAD;
    logic                    LEN_POP;
    logic                    OVERFLOW;
    logic [7:0]              DROP_CNT;
`ifdef MSG_CHECKSUM_EN
    logic [7:0]              MSG_CSUM;
    logic                    CSUM_OK;
`endif

    modport slave (
        input  rx_data, rx_valid, rx_busy, RD_REQ, LEN_POP,
        output rx_ready, FIFO_Q, MSG_VALID, MSG_LEN, MSG_PAD, OVERFLOW, DROP_CNT
`ifdef MSG_CHECKSUM_EN
        , output MSG_CSUM, CSUM_OK
`endif
    );

    modport master (
        output rx_data, rx_valid, rx_busy, RD_REQ, LEN_POP,
        input  rx_ready, FIFO_Q, MSG_VALID, MSG_LEN, MSG_PAD, OVERFLOW, DROP_CNT
`ifdef MSG_CHECKSUM_EN
        , input MSG_CSUM, CSUM_OK
`endif
    );
endinterface

// File: rtl/uart_msg_framer.sv
// Purpose : packs UART RX bytes big-endian into words, closes a message after an idle gap of
//           GAP_MULT byte-times, and commits words plus a {len,pad} descriptor to two FIFOs.
// Latency : a message becomes visible (MSG_VALID) one cycle after the gap-expiry close.
// Backpressure: none toward RX; a full word or descriptor FIFO drops the whole message (OVERFLOW).
// Ports   : CLK, RST (async active-low), bus (uart_msg_framer_if.slave, see the interface file).
// Option  : define MSG_CHECKSUM_EN to add MSG_CSUM (XOR of the head message bytes) and CSUM_OK.
module uart_msg_framer #(
    parameter int         WORD_BYTES  = 2,
    parameter int         WDEPTH_LOG2 = 7,
    parameter int         DDEPTH_LOG2 = 2,
    parameter int         GAP_MULT    = 2,
    parameter int         CNT_W       = 20,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    uart_msg_framer_if.slave  bus
);
    localparam int W      = 8 * WORD_BYTES;
    localparam int WDEPTH = 1 << WDEPTH_LOG2;
    localparam int DDEPTH = 1 << DDEPTH_LOG2;
    localparam int PW     = WDEPTH_LOG2 + 1;
    localparam int DPW    = DDEPTH_LOG2 + 1;
    localparam logic [CNT_W+1:0] GAP_MULT_X = (CNT_W+2)'(GAP_MULT);

    typedef enum logic [1:0] {IDLE, MEASURE, GAP} state_t;

    typedef struct packed {
        logic [PW-1:0] len;
        logic [1:0]    pad;
`ifdef MSG_CHECKSUM_EN
        logic [7:0]    csum;
`endif
    } desc_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   meas_q, meas_d;
    logic [CNT_W-1:0]   btime_q, btime_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [W-1:0]       part_q, part_d;
    logic [2:0]         nb_q, nb_d;
    logic               drop_q, drop_d;
    logic [PW-1:0]      wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    logic [DPW-1:0]     dwptr_q, dwptr_d, drptr_q, drptr_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
`ifdef MSG_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic [W-1:0]       wmem [WDEPTH];
    desc_t              dmem [DDEPTH];

    logic               close, wr_en, drop_now, desc_push;
    logic [W-1:0]       wr_word, shifted, aligned;
    logic [2:0]         nb_inc;
    desc_t              desc_new, desc_head;
    logic [CNT_W+1:0]   thr;
    logic               word_full, desc_full, desc_vld, word_vld;

    assign thr       = GAP_MULT_X * {2'b00, btime_q};
    // Full counts uncommitted words too: the writer may never lap the reader.
    assign word_full = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    assign desc_full = (dwptr_q[DPW-1] != drptr_q[DPW-1]) && (dwptr_q[DPW-2:0] == drptr_q[DPW-2:0]);
    assign desc_vld  = (dwptr_q != drptr_q);
    // The reader only ever sees words below the commit pointer.
    assign word_vld  = (rptr_q != cptr_q);
    assign desc_head = dmem[drptr_q[DPW-2:0]];

    always_comb begin
        state_d    = state_q;
        meas_d     = meas_q;
        btime_d    = btime_q;
        gap_d      = gap_q;
        part_d     = part_q;
        nb_d       = nb_q;
        drop_d     = drop_q;
        wptr_d     = wptr_q;
        cptr_d     = cptr_q;
        rptr_d     = rptr_q;
        dwptr_d    = dwptr_q;
        drptr_d    = drptr_q;
        ovf_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
`ifdef MSG_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        close      = 1'b0;
        wr_en      = 1'b0;
        wr_word    = '0;
        drop_now   = 1'b0;
        desc_push  = 1'b0;
        desc_new   = '0;
        aligned    = '0;
        shifted    = W'({part_q, bus.rx_data});
        nb_inc     = nb_q + 3'd1;

        // Byte-time measurement and end-of-message gap detection.
        unique case (state_q)
            IDLE: begin
                if (bus.rx_busy) begin
                    state_d = MEASURE;
                    meas_d  = '0;
                end
            end
            MEASURE: begin
                if (bus.rx_busy) begin
                    if (meas_q != '1) meas_d = meas_q + 1'b1;
                end else begin
                    btime_d = meas_q;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (bus.rx_busy) begin
                    state_d = MEASURE;
                    meas_d  = '0;
                end else if ({2'b00, gap_q} >= thr) begin
                    close   = 1'b1;
                    state_d = IDLE;
                end else if (gap_q != '1) begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte assembly; bytes of an already-dropped message are discarded.
        if (bus.rx_valid && !drop_q) begin
`ifdef MSG_CHECKSUM_EN
            csum_d = csum_q ^ bus.rx_data;
`endif
            if (nb_inc == 3'(WORD_BYTES)) begin
                wr_en   = 1'b1;
                wr_word = shifted;
                part_d  = '0;
                nb_d    = '0;
            end else begin
                part_d = shifted;
                nb_d   = nb_inc;
            end
        end

        // Flush of a partial last word; a byte arriving in the close cycle is already in part_d,
        // and a word completed this cycle leaves nb_d at zero, so at most one write happens.
        aligned = part_d << (8 * (WORD_BYTES - int'(nb_d)));
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i < WORD_BYTES - int'(nb_d)) aligned[8*i +: 8] = PAD_BYTE;
        end
        if (close && !drop_q && (nb_d != '0)) begin
            wr_en   = 1'b1;
            wr_word = aligned;
        end

        if (wr_en) begin
            if (word_full) drop_now = 1'b1;
            else           wptr_d   = wptr_q + 1'b1;
        end

        if (close) begin
            // wptr_d == cptr_q means no byte survived: spurious busy, or already dropped.
            if (!drop_q && !drop_now && (wptr_d != cptr_q)) begin
                if (desc_full) begin
                    drop_now = 1'b1;
                end else begin
                    desc_push    = 1'b1;
                    desc_new.len = wptr_d - cptr_q;
                    desc_new.pad = (nb_d != '0) ? 2'(WORD_BYTES - int'(nb_d)) : 2'd0;
`ifdef MSG_CHECKSUM_EN
                    desc_new.csum = csum_d;
`endif
                    cptr_d = wptr_d;
                end
            end
            drop_d = 1'b0;
            part_d = '0;
            nb_d   = '0;
`ifdef MSG_CHECKSUM_EN
            csum_d = '0;
`endif
        end

        // Drop rewinds to the last commit; stay in discard mode only if the message continues.
        if (drop_now) begin
            ovf_d  = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            wptr_d = cptr_q;
            part_d = '0;
            nb_d   = '0;
            drop_d = !close;
`ifdef MSG_CHECKSUM_EN
            csum_d = '0;
`endif
        end

        if (desc_push)                 dwptr_d = dwptr_q + 1'b1;
        if (bus.RD_REQ && word_vld)    rptr_d  = rptr_q + 1'b1;
        if (bus.LEN_POP && desc_vld)   drptr_d = drptr_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            meas_q     <= '0;
            btime_q    <= '0;
            gap_q      <= '0;
            part_q     <= '0;
            nb_q       <= '0;
            drop_q     <= 1'b0;
            wptr_q     <= '0;
            cptr_q     <= '0;
            rptr_q     <= '0;
            dwptr_q    <= '0;
            drptr_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
`ifdef MSG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            meas_q     <= meas_d;
            btime_q    <= btime_d;
            gap_q      <= gap_d;
            part_q     <= part_d;
            nb_q       <= nb_d;
            drop_q     <= drop_d;
            wptr_q     <= wptr_d;
            cptr_q     <= cptr_d;
            rptr_q     <= rptr_d;
            dwptr_q    <= dwptr_d;
            drptr_q    <= drptr_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef MSG_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Storage arrays carry no reset; reads are masked by the valid flags.
    always_ff @(posedge CLK) begin
        if (wr_en && !word_full) wmem[wptr_q[PW-2:0]]  <= wr_word;
        if (desc_push)           dmem[dwptr_q[DPW-2:0]] <= desc_new;
    end

    assign bus.rx_ready  = 1'b1;
    assign bus.FIFO_Q    = word_vld ? wmem[rptr_q[PW-2:0]] : '0;
    assign bus.MSG_VALID = desc_vld;
    assign bus.MSG_LEN   = desc_vld ? desc_head.len : '0;
    assign bus.MSG_PAD   = desc_vld ? desc_head.pad : '0;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.DROP_CNT  = drop_cnt_q;
`ifdef MSG_CHECKSUM_EN
    assign bus.MSG_CSUM  = desc_vld ? desc_head.csum : '0;
    assign bus.CSUM_OK   = desc_vld && (desc_head.csum == 8'h00);
`endif
endmodule
